// File: rtl/id_ex_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the ID/EX hazard controller.
// The master side drives instruction/status information; the slave side returns enables, flushes and counters.
interface id_ex_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      ID_Instruction;
  logic             ID_UsesRt;
  logic [31:0]      EX_Instruction;
  logic [1:0]       EX_MemRead;
  logic             EX_RegWrite;
  logic             EX_RegDst;
  logic             EX_Redirect;
  logic             MemBusy;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Write;
  logic             ID_EX_Flush;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_Instruction, ID_UsesRt, EX_Instruction, EX_MemRead,
           EX_RegWrite, EX_RegDst, EX_Redirect, MemBusy,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           StallCycles, FlushCount
  );

  modport slave (
    input  ID_Instruction, ID_UsesRt, EX_Instruction, EX_MemRead,
           EX_RegWrite, EX_RegDst, EX_Redirect, MemBusy,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
           StallCycles, FlushCount
  );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use / redirect / memory-freeze hazard controller for the PC, IF/ID and ID/EX registers.
// Mealy outputs; saturating performance counters for stall cycles and flush events.
module id_ex_hazard_ctrl #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  id_ex_hazard_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0]       REM_INIT = 2'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [4:0]       ldst_q, ldst_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0] dst_s;
  logic       hz_s;
  logic       pc_we_s, ifid_we_s, ifid_fl_s, idex_we_s, idex_fl_s;
  logic       unused_bits_s;

  assign unused_bits_s = ^{bus.ID_Instruction[31:26], bus.ID_Instruction[15:0],
                           bus.EX_Instruction[31:21], bus.EX_Instruction[10:0]};

  // Destination of the EX instruction and load-use hazard detection against ID sources.
  always_comb begin
    dst_s = bus.EX_RegDst ? bus.EX_Instruction[15:11] : bus.EX_Instruction[20:16];
    hz_s  = (bus.EX_MemRead != 2'b00) && bus.EX_RegWrite && (dst_s != 5'd0) &&
            ((dst_s == bus.ID_Instruction[25:21]) ||
             (bus.ID_UsesRt && (dst_s == bus.ID_Instruction[20:16])));
  end

  // Next-state, counter and raw control decode; MemBusy freezes everything.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    ldst_d      = ldst_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_we_s     = 1'b1;
    ifid_we_s   = 1'b1;
    ifid_fl_s   = 1'b0;
    idex_we_s   = 1'b1;
    idex_fl_s   = 1'b0;

    if (bus.MemBusy) begin
      pc_we_s   = 1'b0;
      ifid_we_s = 1'b0;
      idex_we_s = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.EX_Redirect) begin
            ifid_fl_s = 1'b1;
            idex_fl_s = 1'b1;
            if (flush_cnt_q != CNT_MAX) begin
              flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else begin
              flush_cnt_d = flush_cnt_q;
            end
          end else if (hz_s) begin
            pc_we_s   = 1'b0;
            ifid_we_s = 1'b0;
            idex_fl_s = 1'b1;
            if (stall_cnt_q != CNT_MAX) begin
              stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
              stall_cnt_d = stall_cnt_q;
            end
            // Extra bubbles only exist when MEM->EX forwarding is absent.
            if (LOAD_USE_STALLS > 1) begin
              state_d = STALL;
              rem_d   = REM_INIT;
              ldst_d  = dst_s;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        STALL: begin
          pc_we_s   = 1'b0;
          ifid_we_s = 1'b0;
          idex_fl_s = 1'b1;
          if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end else begin
            stall_cnt_d = stall_cnt_q;
          end
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = RUN;
          end else begin
            state_d = STALL;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= RUN;
      rem_q       <= 2'd0;
      ldst_q      <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      ldst_q      <= ldst_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset overrides the decoded controls so the front end stays quiet and ID/EX holds a bubble.
  always_comb begin
    if (!Reset_n) begin
      bus.PCWrite     = 1'b0;
      bus.IF_ID_Write = 1'b0;
      bus.IF_ID_Flush = 1'b1;
      bus.ID_EX_Write = 1'b1;
      bus.ID_EX_Flush = 1'b1;
    end else begin
      bus.PCWrite     = pc_we_s;
      bus.IF_ID_Write = ifid_we_s;
      bus.IF_ID_Flush = ifid_fl_s;
      bus.ID_EX_Write = idex_we_s;
      bus.ID_EX_Flush = idex_fl_s;
    end
  end

  assign bus.StallCycles = stall_cnt_q;
  assign bus.FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Randomized + directed bench for id_ex_hazard_ctrl: three instances with different
// stall depths / counter widths checked against a bubbles-owed reference model.
module tb_id_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic        uses_rt = 1'b0;
  logic [31:0] ex_instr = 32'd0;
  logic [1:0]  mem_read = 2'd0;
  logic        reg_write = 1'b0;
  logic        reg_dst = 1'b0;
  logic        redirect = 1'b0;
  logic        mem_busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_hazard_ctrl_if #(.CNT_W(16)) if0 ();
  id_ex_hazard_ctrl_if #(.CNT_W(4))  if1 ();
  id_ex_hazard_ctrl_if #(.CNT_W(16)) if2 ();

  assign if0.ID_Instruction = id_instr;  assign if1.ID_Instruction = id_instr;  assign if2.ID_Instruction = id_instr;
  assign if0.ID_UsesRt      = uses_rt;   assign if1.ID_UsesRt      = uses_rt;   assign if2.ID_UsesRt      = uses_rt;
  assign if0.EX_Instruction = ex_instr;  assign if1.EX_Instruction = ex_instr;  assign if2.EX_Instruction = ex_instr;
  assign if0.EX_MemRead     = mem_read;  assign if1.EX_MemRead     = mem_read;  assign if2.EX_MemRead     = mem_read;
  assign if0.EX_RegWrite    = reg_write; assign if1.EX_RegWrite    = reg_write; assign if2.EX_RegWrite    = reg_write;
  assign if0.EX_RegDst      = reg_dst;   assign if1.EX_RegDst      = reg_dst;   assign if2.EX_RegDst      = reg_dst;
  assign if0.EX_Redirect    = redirect;  assign if1.EX_Redirect    = redirect;  assign if2.EX_Redirect    = redirect;
  assign if0.MemBusy        = mem_busy;  assign if1.MemBusy        = mem_busy;  assign if2.MemBusy        = mem_busy;

  id_ex_hazard_ctrl #(.LOAD_USE_STALLS(1), .CNT_W(16)) u0 (.Clk(clk), .Reset_n(rstn), .bus(if0));
  id_ex_hazard_ctrl #(.LOAD_USE_STALLS(2), .CNT_W(4))  u1 (.Clk(clk), .Reset_n(rstn), .bus(if1));
  id_ex_hazard_ctrl #(.LOAD_USE_STALLS(3), .CNT_W(16)) u2 (.Clk(clk), .Reset_n(rstn), .bus(if2));

  // Packed view of each instance: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush}.
  logic [4:0]  outs [3];
  logic [15:0] scnt [3];
  logic [15:0] fcnt [3];
  assign outs[0] = {if0.PCWrite, if0.IF_ID_Write, if0.IF_ID_Flush, if0.ID_EX_Write, if0.ID_EX_Flush};
  assign outs[1] = {if1.PCWrite, if1.IF_ID_Write, if1.IF_ID_Flush, if1.ID_EX_Write, if1.ID_EX_Flush};
  assign outs[2] = {if2.PCWrite, if2.IF_ID_Write, if2.IF_ID_Flush, if2.ID_EX_Write, if2.ID_EX_Flush};
  assign scnt[0] = if0.StallCycles;
  assign scnt[1] = {12'd0, if1.StallCycles};
  assign scnt[2] = if2.StallCycles;
  assign fcnt[0] = if0.FlushCount;
  assign fcnt[1] = {12'd0, if1.FlushCount};
  assign fcnt[2] = if2.FlushCount;

  // Reference model: number of load-use bubbles still owed, plus plain integer counters.
  int lus   [3] = '{1, 2, 3};
  int cmax  [3] = '{65535, 15, 65535};
  int owed  [3] = '{0, 0, 0};
  int m_stall [3] = '{0, 0, 0};
  int m_flush [3] = '{0, 0, 0};

  localparam logic [4:0] O_RESET = 5'b00111;
  localparam logic [4:0] O_FREEZE = 5'b00000;
  localparam logic [4:0] O_FLUSH = 5'b11111;
  localparam logic [4:0] O_BUBBLE = 5'b00011;
  localparam logic [4:0] O_RUN = 5'b11010;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_hz();
    int dst;
    int rs;
    int rt;
    dst = reg_dst ? int'(ex_instr[15:11]) : int'(ex_instr[20:16]);
    rs  = int'(id_instr[25:21]);
    rt  = int'(id_instr[20:16]);
    return (mem_read != 2'd0) && reg_write && (dst != 0) && ((dst == rs) || (uses_rt && dst == rt));
  endfunction

  // One clock cycle: drive, check Mealy outputs at negedge, check counters after the rising edge.
  task automatic cyc(input bit r, input int rs, input int rt, input bit ur, input int ert, input int erd,
                     input int mr, input bit rw, input bit rdst, input bit redir, input bit busy);
    logic [4:0] exp_o;
    rstn      = r;
    id_instr  = {6'($urandom), 5'(rs), 5'(rt), 16'($urandom)};
    uses_rt   = ur;
    ex_instr  = {11'($urandom), 5'(ert), 5'(erd), 11'($urandom)};
    mem_read  = 2'(mr);
    reg_write = rw;
    reg_dst   = rdst;
    redirect  = redir;
    mem_busy  = busy;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        owed[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        exp_o = O_RESET;
      end else if (busy) begin
        exp_o = O_FREEZE;
      end else if (owed[i] > 0) begin
        exp_o = O_BUBBLE;
        owed[i]--;
        if (m_stall[i] < cmax[i]) m_stall[i]++;
      end else if (redir) begin
        exp_o = O_FLUSH;
        if (m_flush[i] < cmax[i]) m_flush[i]++;
      end else if (model_hz()) begin
        exp_o = O_BUBBLE;
        owed[i] = lus[i] - 1;
        if (m_stall[i] < cmax[i]) m_stall[i]++;
      end else begin
        exp_o = O_RUN;
      end
      check_val($sformatf("u%0d.ctl", i), 32'(outs[i]), 32'(exp_o));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("u%0d.StallCycles", i), 32'(scnt[i]), 32'(m_stall[i]));
      check_val($sformatf("u%0d.FlushCount", i), 32'(fcnt[i]), 32'(m_flush[i]));
    end
  endtask

  //        rst rs rt ur ert erd mr rw rdst redir busy
  task automatic idle(); cyc(1, 1, 2, 1, 3, 4, 0, 1, 0, 0, 0); endtask
  task automatic lw8_use(); cyc(1, 8, 0, 0, 8, 0, 1, 1, 0, 0, 0); endtask

  initial begin
    // Reset, then T2 basic load-use
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    lw8_use();
    repeat (3) idle();
    // T3 no false stalls: dest $0, rt-only match without UsesRt, no MemRead
    cyc(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 5, 9, 0, 9, 0, 2, 1, 0, 0, 0);
    cyc(1, 9, 9, 1, 0, 9, 0, 1, 1, 0, 0);
    // T4 hazard, freeze, drain
    lw8_use();
    cyc(1, 8, 0, 0, 8, 0, 1, 1, 0, 0, 1);
    repeat (4) idle();
    // T5 redirect beats hazard
    cyc(1, 8, 0, 0, 8, 0, 1, 1, 0, 1, 0);
    repeat (2) idle();
    // T1 reset in the middle of a stall
    lw8_use();
    idle();
    cyc(0, 8, 0, 0, 8, 0, 1, 1, 0, 0, 0);
    repeat (2) idle();
    // T6 saturation of both counters, redirect held off by MemBusy
    repeat (20) lw8_use();
    repeat (3) idle();
    cyc(1, 1, 2, 1, 3, 4, 0, 1, 0, 1, 1);
    cyc(1, 1, 2, 1, 3, 4, 0, 1, 0, 1, 0);
    repeat (20) cyc(1, 1, 2, 1, 3, 4, 0, 1, 0, 1, 0);
    idle();
    // Randomized traffic over a small register set so hazards are frequent
    repeat (800) begin
      cyc(($urandom_range(0, 99) > 1),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
